// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: runs one req/ack transaction per
// load/store, stalls the pipeline meanwhile and flags illegal or timed-out accesses.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  MEM_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter value on the last BUSY cycle before the access is abandoned.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 32'd0) ? 32'd0 : TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

    state_t            state_r;
    state_t            next_state_s;
    logic              accept_s;
    logic              illegal_s;
    logic              ack_s;
    logic              timeout_s;
    logic              stall_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              req_r;
    logic              we_r;
    logic [31:0]       addr_r;
    logic [31:0]       wdata_r;
    logic [31:0]       data_r;
    logic              err_r;

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode, access classification and the combinational stall.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        illegal_s    = 1'b0;
        ack_s        = 1'b0;
        timeout_s    = 1'b0;
        stall_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((MEM_i == 2'b10) || (MEM_i == 2'b01)) begin
                    if (addr_i[1:0] == 2'b00) begin
                        accept_s     = 1'b1;
                        stall_s      = 1'b1;
                        next_state_s = ST_BUSY;
                    end else begin
                        illegal_s    = 1'b1;
                        next_state_s = ST_IDLE;
                    end
                end else if (MEM_i == 2'b11) begin
                    illegal_s    = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                stall_s = 1'b1;
                // An ack on the timeout cycle still completes normally.
                if (mem_ack_i) begin
                    ack_s        = 1'b1;
                    next_state_s = ST_DONE;
                end else if ((TIMEOUT != 32'd0) && (cnt_r == TO_LAST)) begin
                    timeout_s    = 1'b1;
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                // MEM_i is deliberately ignored so the finished instruction is not re-issued.
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Memory-port, load-data, counter and error registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            data_r  <= 32'd0;
            cnt_r   <= '0;
            err_r   <= 1'b0;
        end else begin
            err_r <= illegal_s | timeout_s;
            if (accept_s) begin
                req_r   <= 1'b1;
                we_r    <= MEM_i[0];
                addr_r  <= {addr_i[31:2], 2'b00};
                wdata_r <= wdata_i;
                cnt_r   <= '0;
            end else if (ack_s) begin
                req_r <= 1'b0;
                if (!we_r) begin
                    data_r <= mem_rdata_i;
                end
            end else if (timeout_s) begin
                req_r <= 1'b0;
                if (!we_r) begin
                    data_r <= 32'hDEAD_BEEF;
                end
            end else if (state_r == ST_BUSY) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign mem_req_o   = req_r;
    assign mem_we_o    = we_r;
    assign mem_addr_o  = addr_r;
    assign mem_wdata_o = wdata_r;
    assign data_o      = data_r;
    assign err_o       = err_r;
    assign stall_o     = stall_s;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (TIMEOUT = 4).
module tb_mem_access_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  MEM_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] data_o;
    logic        stall_o;
    logic        err_o;

    int errors = 0;
    int checks = 0;

    int          a_stall, a_req, a_err, a_err_at;
    logic [31:0] a_addr, a_wd;
    logic        a_we;

    mem_access_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .MEM_i(MEM_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .data_o(data_o), .stall_o(stall_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one access, acks on the given BUSY cycle (0 = never) and
    // retires the instruction from EX/MEM after the first non-stalled cycle.
    task automatic do_access(input logic [1:0] mem, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd, input int ack_at);
        int   busy;
        logic low_seen;
        busy = 0; low_seen = 1'b0;
        a_stall = 0; a_req = 0; a_err = 0; a_err_at = -1;
        a_addr = 32'd0; a_wd = 32'd0; a_we = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk_i); #1;
            if (c == 0) begin
                MEM_i = mem; addr_i = addr; wdata_i = wd;
            end else if (low_seen) begin
                MEM_i = 2'b00;
            end
            mem_ack_i   = 1'b0;
            mem_rdata_i = 32'hBAD0_BAD0;
            if (mem_req_o) begin
                busy++;
                if (busy == 1) begin
                    a_addr = mem_addr_o; a_we = mem_we_o; a_wd = mem_wdata_o;
                end
                if (busy == ack_at) begin
                    mem_ack_i = 1'b1; mem_rdata_i = rd;
                end
            end
            #1;
            if (stall_o) a_stall++; else low_seen = 1'b1;
            if (mem_req_o) a_req++;
            if (err_o) begin
                a_err++;
                if (a_err_at < 0) a_err_at = c;
            end
        end
        mem_ack_i = 1'b0;
    endtask

    initial begin
        int   rises, second_at;
        logic prev_req;
        rst_i = 1'b0; MEM_i = 2'b00; addr_i = 32'd0; wdata_i = 32'd0;
        mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_req",   {31'd0, mem_req_o}, 32'd0);
        check_eq("rst_we",    {31'd0, mem_we_o},  32'd0);
        check_eq("rst_addr",  mem_addr_o,         32'd0);
        check_eq("rst_wdata", mem_wdata_o,        32'd0);
        check_eq("rst_data",  data_o,             32'd0);
        check_eq("rst_err",   {31'd0, err_o},     32'd0);
        check_eq("rst_stall", {31'd0, stall_o},   32'd0);
        rst_i = 1'b1;

        do_access(2'b10, 32'h0000_0010, 32'd0, 32'h1234_5678, 3);
        check_eq("ld_stall", a_stall, 32'd4);
        check_eq("ld_req",   a_req,   32'd3);
        check_eq("ld_err",   a_err,   32'd0);
        check_eq("ld_addr",  a_addr,  32'h10);
        check_eq("ld_we",    {31'd0, a_we}, 32'd0);
        check_eq("ld_data",  data_o,  32'h1234_5678);

        do_access(2'b01, 32'h0000_0020, 32'hCAFE_F00D, 32'h7777_7777, 1);
        check_eq("st_stall", a_stall, 32'd2);
        check_eq("st_req",   a_req,   32'd1);
        check_eq("st_we",    {31'd0, a_we}, 32'd1);
        check_eq("st_wdata", a_wd,    32'hCAFE_F00D);
        check_eq("st_addr",  a_addr,  32'h20);
        check_eq("st_err",   a_err,   32'd0);
        check_eq("st_data",  data_o,  32'h1234_5678);

        do_access(2'b10, 32'h0000_0013, 32'd0, 32'h0, 1);
        check_eq("mis_req",    a_req,    32'd0);
        check_eq("mis_stall",  a_stall,  32'd0);
        check_eq("mis_err",    a_err,    32'd1);
        check_eq("mis_err_at", a_err_at, 32'd1);
        check_eq("mis_data",   data_o,   32'h1234_5678);

        do_access(2'b11, 32'h0000_0020, 32'd0, 32'h0, 1);
        check_eq("rw_req",    a_req,    32'd0);
        check_eq("rw_stall",  a_stall,  32'd0);
        check_eq("rw_err",    a_err,    32'd1);
        check_eq("rw_err_at", a_err_at, 32'd1);

        do_access(2'b01, 32'h0000_0022, 32'h1, 32'h0, 1);
        check_eq("mis_st_req", a_req, 32'd0);
        check_eq("mis_st_err", a_err, 32'd1);

        do_access(2'b10, 32'h0000_0030, 32'd0, 32'h0, 0);
        check_eq("to_req",    a_req,    32'd4);
        check_eq("to_stall",  a_stall,  32'd5);
        check_eq("to_err",    a_err,    32'd1);
        check_eq("to_err_at", a_err_at, 32'd5);
        check_eq("to_data",   data_o,   32'hDEAD_BEEF);

        do_access(2'b10, 32'h0000_0034, 32'd0, 32'h55AA_55AA, 4);
        check_eq("to_ack_req",  a_req,   32'd4);
        check_eq("to_ack_err",  a_err,   32'd0);
        check_eq("to_ack_data", data_o,  32'h55AA_55AA);

        // Same load held in EX/MEM across DONE.
        rises = 0; second_at = -1; prev_req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk_i); #1;
            MEM_i = 2'b10; addr_i = 32'h0000_0040;
            mem_ack_i = mem_req_o;
            mem_rdata_i = 32'hA000_0000 | c;
            #1;
            if (mem_req_o && !prev_req) begin
                rises++;
                if (rises == 2) second_at = c;
            end
            prev_req = mem_req_o;
        end
        @(posedge clk_i); #1;
        MEM_i = 2'b00; mem_ack_i = 1'b0;
        #1;
        check_eq("b2b_rises",  rises,     32'd2);
        check_eq("b2b_second", second_at, 32'd4);
        check_eq("b2b_data",   data_o,    32'hA000_0004);
        check_eq("b2b_idle",   {31'd0, mem_req_o}, 32'd0);

        // Reset in the middle of a transaction.
        @(posedge clk_i); #1;
        MEM_i = 2'b10; addr_i = 32'h0000_0044;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check_eq("mid_req_hi", {31'd0, mem_req_o}, 32'd1);
        MEM_i = 2'b00; rst_i = 1'b0;
        #1;
        check_eq("mid_rst_req",   {31'd0, mem_req_o}, 32'd0);
        check_eq("mid_rst_addr",  mem_addr_o,         32'd0);
        check_eq("mid_rst_data",  data_o,             32'd0);
        check_eq("mid_rst_stall", {31'd0, stall_o},   32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_1111;
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        #1;
        check_eq("post_ack_req",   {31'd0, mem_req_o}, 32'd0);
        check_eq("post_ack_data",  data_o,             32'd0);
        check_eq("post_ack_err",   {31'd0, err_o},     32'd0);
        check_eq("post_ack_stall", {31'd0, stall_o},   32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Data-memory access controller for the MEM stage of the 5-stage pipeline; sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Takes the load/store command and address from EX/MEM and runs a variable-latency req/ack transaction on the data-memory port.
- Stalls the pipeline for the duration of the transaction, then presents load data to MEM/WB's data input.
- Flags misaligned, illegal and timed-out accesses.

Parameters:
- TIMEOUT, 16, max cycles mem_req_o may stay high without mem_ack_i; 0 disables timeout.
- CNT_W, 8, width of the timeout counter; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk_i  input  1  clock, rising-edge.
- rst_i  input  1  reset, asynchronous, active-low.
- MEM_i  input  2  control from EX/MEM: bit1 = MemRead, bit0 = MemWrite.
- addr_i  input  32  byte address (ALU result) from EX/MEM.
- wdata_i  input  32  store data from EX/MEM.
- mem_ack_i  input  1  memory completion, sampled only in BUSY.
- mem_rdata_i  input  32  memory read data, valid with mem_ack_i.
- mem_req_o  output  1  memory request.
- mem_we_o  output  1  1 = write, 0 = read.
- mem_addr_o  output  32  word-aligned address to memory.
- mem_wdata_o  output  32  write data to memory.
- data_o  output  32  load result to MEM/WB data_i.
- stall_o  output  1  freezes PC, IF/ID, ID/EX and EX/MEM; MEM/WB takes a bubble (WB = 0) while high.
- err_o  output  1  one-cycle pulse on a faulted access.

Behaviour:
- Reset: state = IDLE. mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, data_o, err_o, timeout counter all 0. stall_o = 0. Reset mid-transaction drops mem_req_o immediately; a later ack is ignored.
- States: IDLE, BUSY, DONE.
- IDLE, MEM_i = 2'b00: stay in IDLE, stall_o = 0.
- IDLE, MEM_i = 2'b10 or 2'b01 with addr_i[1:0] == 0: accept the access.
  - stall_o = 1 combinationally in this cycle.
  - At the clock edge: register addr, wdata and we; set mem_req_o = 1; clear counter; go to BUSY.
- IDLE, MEM_i = 2'b11, or addr_i[1:0] != 0 with a read/write:
  - Illegal access; no request issued, stall_o = 0.
  - err_o = 1 in the following cycle for exactly one cycle; data_o unchanged.
- BUSY: stall_o = 1. mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are held stable until ack or timeout.
- BUSY, mem_ack_i = 1:
  - Drop mem_req_o.
  - If read, data_o <= mem_rdata_i; if write, data_o is unchanged.
  - Go to DONE.
- BUSY, no ack:
  - Counter increments each cycle.
  - When TIMEOUT != 0 and the counter reaches TIMEOUT-1 without ack: drop mem_req_o; err_o pulses 1 cycle; data_o <= 32'hDEADBEEF if read; go to DONE.
  - An ack in the same cycle as the timeout wins (normal completion, no err).
- DONE: stall_o = 0 for one cycle, so the pipeline advances and MEM/WB captures data_o. Always return to IDLE; MEM_i is not evaluated in DONE, so the completed instruction is never re-issued.
- Latency:
  - Access presented at cycle T; mem_req_o high from T+1.
  - Ack sampled at T+k (k ≥ 1) gives DONE at T+k+1.
  - stall_o is high for cycles T..T+k, i.e. k+1 stall cycles; minimum is 2.
- mem_ack_i outside BUSY is ignored. data_o holds its value between loads.

Test Plan:
- Reset with rst_i = 0 mid-BUSY (mem_req_o = 1) -> all outputs 0 asynchronously, state IDLE; an ack at the next cycle has no effect.
- Load: MEM_i = 2'b10, addr_i = 32'h0000_0010, ack 3 cycles after mem_req_o rises with mem_rdata_i = 32'h1234_5678.
  - mem_addr_o = 32'h10, mem_we_o = 0.
  - stall_o high 4 cycles.
  - data_o = 32'h12345678 in DONE; err_o = 0.
- Store: MEM_i = 2'b01, addr_i = 32'h20, wdata_i = 32'hCAFE_F00D, ack on the first BUSY cycle.
  - mem_we_o = 1 and mem_wdata_o = 32'hCAFEF00D while req is high.
  - stall_o high exactly 2 cycles; data_o unchanged.
- Misaligned: MEM_i = 2'b10, addr_i = 32'h13 -> mem_req_o stays 0, stall_o = 0, err_o pulses once the next cycle. Repeat with MEM_i = 2'b11 for the same result.
- Timeout: TIMEOUT = 4, load with no ack -> mem_req_o high exactly 4 cycles, then err_o pulse, data_o = 32'hDEADBEEF, IDLE two cycles later.
- Back-to-back loads held in EX/MEM across DONE -> exactly one request per instruction; the second request is issued from the IDLE cycle after DONE.
